// File: rtl/seg7_frame_scan_pkg.sv
// Shared constants for the 8-digit seven-segment scanner: blanking codes and the
// active-high gfedcba hex glyph table.
package seg7_frame_scan_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEL_OFF = 8'hFF;

  // Entry n holds the glyph for hex digit n; entry 15 is listed first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_frame_scan_hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment glyph (bit 0 = a .. bit 6 = g).
module hex_to_seg7
  import seg7_frame_scan_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_hex];

endmodule

// File: rtl/seg7_frame_scan.sv
// 8-digit multiplexed hex display driver with a 1-deep shadow buffer that is swapped
// into the displayed word only at frame boundaries, leading-zero blanking and 16-level PWM.
module seg7_frame_scan
  import seg7_frame_scan_pkg::*;
#(
  parameter int unsigned CNT_W    = 17,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  output logic        o_ready,
  input  logic        blank_lz,
  input  logic [3:0]  bright,
  output logic [7:0]  o_sel,
  output logic [7:0]  o_seg
);

  localparam int unsigned      PH_DIV     = SCAN_DIV / 16;
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] SUB_LAST   = CNT_W'(PH_DIV - 1);

  logic [CNT_W-1:0] r_presc;
  logic [CNT_W-1:0] r_sub;
  logic [3:0]       r_ph;
  logic [2:0]       r_idx;
  logic [31:0]      r_shadow;
  logic [31:0]      r_active;
  logic             r_pending;
  logic [7:0]       r_sel;
  logic [7:0]       r_seg;

  logic        w_tick;
  logic        w_frame_end;
  logic        w_accept;
  logic [31:0] w_upper;
  logic        w_blank;
  logic        w_lit;
  logic [3:0]  w_nib;
  logic [6:0]  w_glyph;
  logic [7:0]  w_sel_d;
  logic [7:0]  w_seg_d;

  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_frame_end = w_tick && (r_idx == 3'd7);
  assign w_accept    = i_valid && !r_pending;
  assign o_ready     = !r_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_sub   <= '0;
      r_ph    <= '0;
      r_idx   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_sub   <= '0;
      r_ph    <= '0;
      r_idx   <= r_idx + 3'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (r_sub == SUB_LAST) begin
        r_sub <= '0;
        // Saturate so a SCAN_DIV that is not a multiple of 16 never wraps the phase.
        if (r_ph != 4'hF) r_ph <= r_ph + 4'd1;
      end else begin
        r_sub <= r_sub + 1'b1;
      end
    end
  end

  // Accept and swap are exclusive: accept needs pending low, swap needs it high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else if (w_frame_end && r_pending) begin
      r_active  <= r_shadow;
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_shadow  <= i_data;
      r_pending <= 1'b1;
    end
  end

  assign w_upper = r_active >> {r_idx, 2'b00};
  assign w_blank = blank_lz && (r_idx != 3'd0) && (w_upper == 32'd0);
  assign w_lit   = (bright == 4'hF) || (r_ph < bright);
  assign w_nib   = r_active[{r_idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .i_hex (w_nib),
    .o_seg (w_glyph)
  );

  always_comb begin
    w_sel_d = SEL_OFF;
    w_seg_d = SEG_OFF;
    if (w_lit && !w_blank) begin
      w_sel_d = ~(8'b1 << r_idx);
      w_seg_d = {1'b1, ~w_glyph};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel <= SEL_OFF;
      r_seg <= SEG_OFF;
    end else begin
      r_sel <= w_sel_d;
      r_seg <= w_seg_d;
    end
  end

  assign o_sel = r_sel;
  assign o_seg = r_seg;

endmodule

// File: tb/tb_seg7_frame_scan.sv
// Directed bench for seg7_frame_scan with SCAN_DIV=32: expected digit frames are queued
// as words are driven and compared at mid-slot of the scheduled cycle.
module tb_seg7_frame_scan;

  localparam int unsigned SLOT  = 32;
  localparam int unsigned FRAME = 8 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_data = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bright = 4'hF;
  logic        o_ready;
  logic [7:0]  o_sel;
  logic [7:0]  o_seg;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    string      tag;
    int         at;
    logic [7:0] sel;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q[$];

  // Active-low segment patterns with dp off, digits 0..F.
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_frame_scan #(
    .CNT_W    (6),
    .SCAN_DIV (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .blank_lz (blank_lz),
    .bright   (bright),
    .o_sel    (o_sel),
    .o_seg    (o_seg)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push_frame(input int frame, input logic [31:0] w, input bit blank);
    for (int k = 0; k < 8; k++) begin
      exp_t       e;
      logic [31:0] up;
      logic [3:0]  nib;
      bit          blanked;
      up      = w >> (4 * k);
      nib     = up[3:0];
      blanked = blank && (k > 0) && (up == 32'd0);
      e.tag   = $sformatf("f%0d_d%0d", frame, k);
      e.at    = frame * FRAME + k * SLOT + 16;
      e.sel   = blanked ? 8'hFF : ~(8'b1 << k);
      e.seg   = blanked ? 8'hFF : seg_tab[nib];
      exp_q.push_back(e);
    end
  endtask

  task automatic push_one(input string tag, input int at, input logic [7:0] sel,
                          input logic [7:0] seg);
    exp_t e;
    e.tag = tag;
    e.at  = at;
    e.sel = sel;
    e.seg = seg;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, "_late"}, 32'(cyc > e.at), 32'd0);
      wait_cyc(e.at);
      chk({e.tag, "_sel"}, 32'(o_sel), 32'(e.sel));
      chk({e.tag, "_seg"}, 32'(o_seg), 32'(e.seg));
    end
  endtask

  task automatic send(input int at, input logic [31:0] w);
    wait_cyc(at);
    i_valid = 1'b1;
    i_data  = w;
    wait_cyc(at + 1);
    i_valid = 1'b0;
    chk($sformatf("ready_low_%0d", at + 1), 32'(o_ready), 32'd0);
  endtask

  initial begin
    int lit;
    int bad;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_sel", 32'(o_sel), 32'hFF);
    chk("rst_seg", 32'(o_seg), 32'hFF);
    rst = 1'b1;

    // Frame 0: all zeros, scan walks FE..7F.
    push_frame(0, 32'h0, 1'b0);
    drain();

    // Mid-frame accept; display holds until frame end.
    send(300, 32'h1234_ABCD);
    push_one("f1_d7_old", FRAME + 7 * SLOT + 16, 8'h7F, 8'hC0);
    drain();
    wait_cyc(FRAME * 2 - 1);
    chk("ready_before_fe", 32'(o_ready), 32'd0);
    wait_cyc(FRAME * 2);
    chk("ready_after_fe", 32'(o_ready), 32'd1);
    push_frame(2, 32'h1234_ABCD, 1'b0);
    drain();

    // Back-to-back producer: W1 waits a whole frame behind W0.
    wait_cyc(780);
    i_valid = 1'b1;
    i_data  = 32'h7777_7777;
    wait_cyc(781);
    i_data  = 32'h9999_9999;
    chk("w0_ready_low", 32'(o_ready), 32'd0);
    wait_cyc(1000);
    chk("w1_held", 32'(o_ready), 32'd0);
    push_one("f3_d7_old", 3 * FRAME + 7 * SLOT + 16, 8'h7F, 8'hF9);
    drain();
    wait_cyc(1024);
    chk("w0_swapped_ready", 32'(o_ready), 32'd1);
    wait_cyc(1025);
    i_valid = 1'b0;
    chk("w1_accepted", 32'(o_ready), 32'd0);
    push_frame(4, 32'h7777_7777, 1'b0);
    drain();

    // Leading-zero blanking; W1 has no zeros so frame 5 is unaffected.
    blank_lz = 1'b1;
    send(1290, 32'h0000_00A0);
    push_frame(5, 32'h9999_9999, 1'b1);
    push_frame(6, 32'h0000_00A0, 1'b1);
    drain();
    send(1800, 32'h0);
    push_frame(8, 32'h0, 1'b1);
    drain();

    // PWM: bright=4 lights each digit for 8 of its 32 cycles.
    wait_cyc(9 * FRAME);
    bright   = 4'd4;
    blank_lz = 1'b0;
    for (int k = 0; k < 8; k++) begin
      lit = 0;
      bad = 0;
      for (int n = 1; n <= int'(SLOT); n++) begin
        wait_cyc(9 * FRAME + k * SLOT + n);
        if (o_sel === ~(8'b1 << k)) lit++;
        else if (o_sel !== 8'hFF) bad++;
      end
      chk($sformatf("pwm4_d%0d_lit", k), 32'(lit), 32'd8);
      chk($sformatf("pwm4_d%0d_bad", k), 32'(bad), 32'd0);
    end
    bright = 4'd0;
    lit = 0;
    for (int n = 1; n <= int'(FRAME); n++) begin
      wait_cyc(10 * FRAME + n);
      if (o_sel !== 8'hFF) lit++;
    end
    chk("pwm0_dark", 32'(lit), 32'd0);

    // Async reset while a word is pending drops it.
    wait_cyc(11 * FRAME);
    bright = 4'hF;
    send(11 * FRAME + 4, 32'hDEAD_BEEF);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ready", 32'(o_ready), 32'd1);
    chk("arst_sel", 32'(o_sel), 32'hFF);
    chk("arst_seg", 32'(o_seg), 32'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_frame(0, 32'h0, 1'b0);
    push_one("post_rst_f1_d0", FRAME + 16, 8'hFE, 8'hC0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
